// File: rtl/pulse_spacer_if.sv
// Event interface between a pulse source and the pulse_spacer conditioning stage.
// Latency: none (wires only).
// Backpressure: none; overload is reported through the sticky overflow flag.
//
// Signals:
//   in_pulse       - event strobe into the spacer (one event per high cycle)
//   overflow_clear - single-cycle clear for the sticky overflow flag
//   out_pulse      - spaced single-cycle event strobe out of the spacer
//   pending        - events accepted but not yet emitted
//   overflow       - sticky flag, an event was dropped at saturation
interface pulse_spacer_if #(
   parameter int PENDING_WIDTH = 4
);
   logic                     in_pulse;
   logic                     overflow_clear;
   logic                     out_pulse;
   logic [PENDING_WIDTH-1:0] pending;
   logic                     overflow;

   // Event source side.
   modport master (
      output in_pulse,
      output overflow_clear,
      input  out_pulse,
      input  pending,
      input  overflow
   );

   // Spacer side.
   modport slave (
      input  in_pulse,
      input  overflow_clear,
      output out_pulse,
      output pending,
      output overflow
   );
endinterface

// File: rtl/pulse_spacer.sv
// Queues single-cycle events and re-emits them at least MIN_GAP cycles apart.
// Latency: 1 cycle from in_pulse to out_pulse when idle with an empty backlog.
// Backpressure: none; events beyond a saturated backlog are dropped and flagged.
//
// Ports:
//   clk - source-domain clock, rising edge
//   rst - synchronous active-high reset
//   bus - pulse_spacer_if slave: in_pulse/overflow_clear in,
//         out_pulse/pending/overflow out (all outputs registered)
module pulse_spacer #(
   parameter int MIN_GAP       = 4,
   parameter int PENDING_WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   pulse_spacer_if.slave  bus
);

   localparam int                       GAP_W    = $clog2(MIN_GAP + 1);
   localparam logic [GAP_W-1:0]         GAP_LOAD = GAP_W'(MIN_GAP - 1);
   localparam logic [GAP_W-1:0]         GAP_ONE  = GAP_W'(1);
   localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
   localparam logic [PENDING_WIDTH-1:0] PEND_ONE = PENDING_WIDTH'(1);

   typedef enum logic {
      READY   = 1'b0,
      HOLDOFF = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [GAP_W-1:0]         gap_q, gap_d;
   logic [PENDING_WIDTH-1:0] pending_q, pending_d;
   logic                     out_q, out_d;
   logic                     ovf_q, ovf_d;

   logic emit;
   logic emit_from_pending;
   logic inc;
   logic drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= READY;
         gap_q     <= '0;
         pending_q <= '0;
         out_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         pending_q <= pending_d;
         out_q     <= out_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      gap_d             = gap_q;
      pending_d         = pending_q;
      ovf_d             = ovf_q;
      drop              = 1'b0;

      emit              = (state_q == READY) && ((pending_q != '0) || bus.in_pulse);
      emit_from_pending = emit && (pending_q != '0);
      // An event arriving while idle with no backlog goes straight out and
      // never touches the counter.
      inc               = bus.in_pulse && !(emit && (pending_q == '0));

      case (state_q)
         READY: begin
            // With MIN_GAP of 1 there is no holdoff: back-to-back emits allowed.
            if (emit && (MIN_GAP > 1)) begin
               gap_d   = GAP_LOAD;
               state_d = HOLDOFF;
            end
         end
         HOLDOFF: begin
            gap_d = gap_q - GAP_ONE;
            if (gap_q == GAP_ONE) begin
               state_d = READY;
            end
         end
         default: begin
            state_d = READY;
            gap_d   = '0;
         end
      endcase

      // Arrival and departure in the same cycle cancel out.
      if (inc && !emit_from_pending) begin
         if (pending_q == PEND_MAX) begin
            drop = 1'b1;
         end else begin
            pending_d = pending_q + PEND_ONE;
         end
      end else if (!inc && emit_from_pending) begin
         pending_d = pending_q - PEND_ONE;
      end

      // A drop in the clearing cycle must stay visible, so set wins.
      if (bus.overflow_clear) begin
         ovf_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end

      out_d = emit;
   end

   assign bus.out_pulse = out_q;
   assign bus.pending   = pending_q;
   assign bus.overflow  = ovf_q;

endmodule
